// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: steers store lanes onto a req/ack data bus,
// extracts and extends load data, flags misaligned accesses and stalls the
// upstream pipeline while a bus access is outstanding.
module mem_stage_lsu #(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        pipe_hold_i,
   input  logic [31:0] ALU_res_in,
   input  logic [31:0] store_data_in,
   input  logic [4:0]  rd_in,
   input  logic        RegWrite_in,
   input  logic        MemRead_in,
   input  logic        MemWrite_in,
   input  logic        MemToReg_in,
   input  logic [6:0]  opcode_in,
   input  logic [31:0] pc_plus_4_in,
   input  logic [31:0] instr_in,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [3:0]  dmem_be,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_ack,
   input  logic [31:0] dmem_rdata,
   output logic        mem_stall,
   output logic [31:0] wb_data,
   output logic [4:0]  rd_out,
   output logic        RegWrite_out,
   output logic        misalign_err,
   output logic        bus_err
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   // Last BUSY count value before the access is abandoned.
   localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

   state_t      state_q, state_d;
   logic        req_q, req_d;
   logic        we_q, we_d;
   logic [31:0] addr_q, addr_d;
   logic [3:0]  be_q, be_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rdata_q, rdata_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        bus_err_q, bus_err_d;
   logic        to_q, to_d;

   logic [2:0]  funct3;
   logic        mem_op;
   logic        misal;
   logic        access;
   logic [3:0]  be_c;
   logic [31:0] wdata_c;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] ld_data;
   logic        unused_instr;

   assign funct3       = instr_in[14:12];
   assign mem_op       = MemRead_in | MemWrite_in;
   assign access       = mem_op & ~misal;
   assign unused_instr = &{1'b0, instr_in[31:15], instr_in[11:0]};

   // Alignment rule per access size: halfwords need an even address, words a 4-byte one.
   always_comb begin
      // NOTE: every signal assigned in always_comb gets a default first, otherwise a latch is inferred.
      misal = 1'b0;
      case (funct3)
         3'b001, 3'b101: misal = ALU_res_in[0];
         3'b010:         misal = |ALU_res_in[1:0];
         default:        misal = 1'b0;
      endcase
   end

   // Store lane steering: byte enables follow the address, data is replicated across lanes.
   always_comb begin
      be_c    = 4'b1111;
      wdata_c = store_data_in;
      case (funct3)
         3'b000: begin
            be_c    = 4'b0001 << ALU_res_in[1:0];
            wdata_c = {4{store_data_in[7:0]}};
         end
         3'b001: begin
            be_c    = ALU_res_in[1] ? 4'b1100 : 4'b0011;
            wdata_c = {2{store_data_in[15:0]}};
         end
         default: begin
            be_c    = 4'b1111;
            wdata_c = store_data_in;
         end
      endcase
   end

   // Load extraction: pick the addressed lane of the captured word and extend it.
   always_comb begin
      ld_byte = rdata_q[{ALU_res_in[1:0], 3'b000} +: 8];
      ld_half = ALU_res_in[1] ? rdata_q[31:16] : rdata_q[15:0];
      case (funct3)
         3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
         3'b100:  ld_data = {24'h0, ld_byte};
         3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
         3'b101:  ld_data = {16'h0, ld_half};
         default: ld_data = rdata_q;
      endcase
   end

   // Access sequencer: issue in IDLE, wait for ack or timeout in BUSY, park in DONE until released.
   always_comb begin
      state_d   = state_q;
      req_d     = req_q;
      we_d      = we_q;
      addr_d    = addr_q;
      be_d      = be_q;
      wdata_d   = wdata_q;
      rdata_d   = rdata_q;
      cnt_d     = cnt_q;
      bus_err_d = 1'b0;
      to_d      = to_q;
      case (state_q)
         IDLE: begin
            if (access) begin
               state_d = BUSY;
               req_d   = 1'b1;
               we_d    = MemWrite_in;
               addr_d  = {ALU_res_in[31:2], 2'b00};
               be_d    = be_c;
               wdata_d = wdata_c;
               cnt_d   = 8'd0;
               to_d    = 1'b0;
            end
         end
         BUSY: begin
            if (dmem_ack) begin
               rdata_d = dmem_rdata;
               req_d   = 1'b0;
               state_d = DONE;
            end else if (cnt_q == TO_LAST) begin
               rdata_d   = 32'h0;
               req_d     = 1'b0;
               bus_err_d = 1'b1;
               to_d      = 1'b1;
               state_d   = DONE;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         DONE: begin
            if (!pipe_hold_i) begin
               state_d = IDLE;
               to_d    = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and registered bus outputs; reset abandons any access in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         req_q     <= 1'b0;
         we_q      <= 1'b0;
         addr_q    <= 32'h0;
         be_q      <= 4'h0;
         wdata_q   <= 32'h0;
         rdata_q   <= 32'h0;
         cnt_q     <= 8'd0;
         bus_err_q <= 1'b0;
         to_q      <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so all flops update together.
         state_q   <= state_d;
         req_q     <= req_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         be_q      <= be_d;
         wdata_q   <= wdata_d;
         rdata_q   <= rdata_d;
         cnt_q     <= cnt_d;
         bus_err_q <= bus_err_d;
         to_q      <= to_d;
      end
   end

   assign dmem_req     = req_q;
   assign dmem_we      = we_q;
   assign dmem_addr    = addr_q;
   assign dmem_be      = be_q;
   assign dmem_wdata   = wdata_q;
   assign bus_err      = bus_err_q;
   assign rd_out       = rd_in;
   assign misalign_err = mem_op & misal;
   assign mem_stall    = access & (state_q != DONE);
   assign RegWrite_out = RegWrite_in & ~(mem_op & misal) & ~(to_q & (state_q == DONE));
   assign wb_data      = (opcode_in == 7'b1101111 || opcode_in == 7'b1100111) ? pc_plus_4_in :
                         MemToReg_in ? ld_data : ALU_res_in;

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- MEM-stage load/store unit sitting directly downstream of the EX/MEM pipeline register; consumes its outputs and produces the write-back data for the MEM/WB register.
- Drives a req/ack data-memory bus and performs byte/halfword/word lane steering, load sign/zero extension and misalignment checks.
- Asserts mem_stall to the hazard unit while a bus access is outstanding, so upstream pipeline registers hold.

Parameters:
- TIMEOUT_CYCLES, 16: BUSY cycles without dmem_ack before the access is abandoned with bus_err; legal range 1..255.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- pipe_hold_i  input  1  stall from other sources; holds the EX/MEM contents
- ALU_res_in  input  32  effective address, or ALU result for non-memory instructions
- store_data_in  input  32  rs2 value to store
- rd_in  input  5  destination register
- RegWrite_in  input  1  register-write enable
- MemRead_in  input  1  load
- MemWrite_in  input  1  store
- MemToReg_in  input  1  select load data for write-back
- opcode_in  input  7  instruction opcode
- pc_plus_4_in  input  32  link value
- instr_in  input  32  instruction word; funct3 = instr_in[14:12]
- dmem_req  output  1  bus request (registered)
- dmem_we  output  1  1 = write (registered)
- dmem_addr  output  32  word address, bits[1:0]=0 (registered)
- dmem_be  output  4  byte enables (registered)
- dmem_wdata  output  32  lane-replicated store data (registered)
- dmem_ack  input  1  access complete; dmem_rdata valid in the same cycle
- dmem_rdata  input  32  read word
- mem_stall  output  1  hold the upstream pipeline
- wb_data  output  32  write-back value
- rd_out  output  5  passthrough of rd_in
- RegWrite_out  output  1  qualified write enable
- misalign_err  output  1  misaligned access (level while the instruction sits in MEM)
- bus_err  output  1  one-cycle pulse on timeout

Behaviour:
- Access condition: access = (MemRead_in | MemWrite_in) & !misal.
- Misalignment (misal):
  - funct3 001/101 (LH, LHU, SH) with addr[0] = 1.
  - funct3 010 (LW, SW) with addr[1:0] != 0.
  - A misaligned access issues no bus transaction and forces RegWrite_out = 0.
  - misalign_err = (MemRead_in | MemWrite_in) & misal, combinational.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: if access, go to BUSY; register dmem_req=1, dmem_we=MemWrite_in, dmem_addr={addr[31:2],2'b00}, dmem_be and dmem_wdata; clear the timeout counter.
  - BUSY: dmem_req held high with all bus outputs stable until dmem_ack.
    - On ack: capture dmem_rdata into rdata_q, drop dmem_req on the next edge, go to DONE.
    - Counter increments each BUSY cycle without ack. When the count reaches TIMEOUT_CYCLES-1 with no ack: drop dmem_req, set rdata_q=0, pulse bus_err for 1 cycle, go to DONE.
  - DONE: the result is valid. Return to IDLE when !pipe_hold_i; otherwise stay in DONE, so the same instruction is never re-issued.
- mem_stall = access & (state != DONE), combinational. Minimum MEM occupancy of a memory instruction is 3 cycles (IDLE, BUSY with ack in the first cycle, DONE).
- Byte enables and store data:
  - SB: be = 4'b0001 << addr[1:0]; wdata = {4{sd[7:0]}}.
  - SH: be = addr[1] ? 1100 : 0011; wdata = {2{sd[15:0]}}.
  - SW: be = 1111; wdata = sd.
  - Any other funct3: treat as SW.
- Load extraction from rdata_q, lane selected by addr[1:0]:
  - LB / LH: sign-extend.
  - LBU / LHU: zero-extend.
  - LW / other funct3: full word.
- wb_data priority:
  - opcode 1101111 or 1100111 (JAL/JALR): pc_plus_4_in.
  - else MemToReg_in: extracted load.
  - else ALU_res_in.
- RegWrite_out = RegWrite_in & !misal_mem & !(timeout flag held in DONE).
  - misal_mem is misal qualified by MemRead_in | MemWrite_in.
  - A load that timed out does not write the register file.
- Non-memory instructions pass straight through combinationally: zero stall, FSM stays in IDLE.
- Reset (asynchronous, also mid-access): state=IDLE; dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, rdata_q, counter, bus_err and timeout flag all 0. The combinational outputs follow their inputs.
- dmem_ack arriving outside BUSY is ignored.

Test Plan:
- SW, addr 0x100, data 0xDEADBEEF, ack 2 cycles after req -> req/we=1, addr 0x100, be 1111, wdata 0xDEADBEEF; mem_stall high for 3 cycles then low for 1; RegWrite_out=0.
- LB addr 0x203, rdata 0x80FF_0000 -> wb_data 0xFFFFFF80. Same access as LBU -> 0x00000080. LH addr 0x202 -> 0xFFFF80FF.
- SB addr 0x7, sd 0x000000A5 -> be 1000, wdata 0xA5A5A5A5. SH addr 0x2 -> be 1100.
- LW addr 0x102 -> no dmem_req, misalign_err=1, RegWrite_out=0, mem_stall=0.
- LW with ack never asserted, TIMEOUT_CYCLES=4 -> bus_err pulses once after 4 BUSY cycles, req drops, RegWrite_out=0 in DONE, FSM returns to IDLE.
- Reset asserted during BUSY -> dmem_req=0 immediately; after release the FSM is in IDLE. pipe_hold_i=1 during DONE -> FSM stays in DONE with a single bus request only.
